// File: rtl/dm_cache.sv
// Direct-mapped, write-back, write-allocate data cache with 16-byte lines and 0-cycle hits.
// Define DM_CACHE_PERF_EN to build the hit/miss counters; otherwise both outputs are tied to 0.
module dm_cache #(
    parameter int NUM_SETS = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [15:0]  mem_address,
    input  logic [15:0]  mem_wdata,
    input  logic [1:0]   mem_byte_enable,
    output logic         mem_resp,
    output logic [15:0]  mem_rdata,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [15:0]  pmem_address,
    output logic [127:0] pmem_wdata,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp,
    output logic [15:0]  hit_count,
    output logic [15:0]  miss_count
);
    localparam int INDEX_W = $clog2(NUM_SETS);
    localparam int TAG_W   = 12 - INDEX_W;

    typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_t;

    state_t state, state_next;

    logic [NUM_SETS-1:0] valid;
    logic [NUM_SETS-1:0] dirty;
    logic [TAG_W-1:0]    tag_arr  [NUM_SETS];
    logic [127:0]        data_arr [NUM_SETS];

    // Request address captured when a miss starts, so a dropped request can still finish cleanly.
    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] req_index;

    logic [TAG_W-1:0]   addr_tag;
    logic [INDEX_W-1:0] addr_index;
    logic [6:0]         bit_lo;
    logic [6:0]         bit_hi;
    logic [15:0]        word_data;
    logic               req;
    logic               hit;
    logic               hit_wr_en;
    logic               fill_en;
    logic               miss_start;
    logic               unused_addr_bit;

    assign addr_tag        = mem_address[15:4+INDEX_W];
    assign addr_index      = mem_address[3+INDEX_W:4];
    assign bit_lo          = {mem_address[3:1], 4'b0000};
    assign bit_hi          = {mem_address[3:1], 4'b1000};
    assign word_data       = data_arr[addr_index][bit_lo +: 16];
    assign req             = mem_read | mem_write;
    assign hit             = valid[addr_index] && (tag_arr[addr_index] == addr_tag);
    assign unused_addr_bit = mem_address[0];

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_next   = state;
        mem_resp     = 1'b0;
        mem_rdata    = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        hit_wr_en    = 1'b0;
        fill_en      = 1'b0;
        miss_start   = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        mem_resp  = 1'b1;
                        mem_rdata = word_data;
                        hit_wr_en = mem_write;
                    end else begin
                        miss_start = 1'b1;
                        state_next = (valid[addr_index] && dirty[addr_index]) ? WRITEBACK : FILL;
                    end
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_arr[req_index], req_index, 4'b0000};
                pmem_wdata   = data_arr[req_index];
                if (pmem_resp) state_next = FILL;
            end
            FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {req_tag, req_index, 4'b0000};
                if (pmem_resp) begin
                    fill_en    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state     <= IDLE;
            valid     <= '0;
            dirty     <= '0;
            req_tag   <= '0;
            req_index <= '0;
        end else begin
            state <= state_next;
            if (miss_start) begin
                req_tag   <= addr_tag;
                req_index <= addr_index;
            end
            if (fill_en) begin
                valid[req_index] <= 1'b1;
                dirty[req_index] <= 1'b0;
            end
            if (hit_wr_en && (mem_byte_enable != 2'b00)) dirty[addr_index] <= 1'b1;
        end
    end

    // NOTE: tag and data arrays are deliberately not reset; clearing valid makes their contents irrelevant.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            data_arr[req_index] <= pmem_rdata;
            tag_arr[req_index]  <= req_tag;
        end
        if (hit_wr_en) begin
            if (mem_byte_enable[0]) data_arr[addr_index][bit_lo +: 8] <= mem_wdata[7:0];
            if (mem_byte_enable[1]) data_arr[addr_index][bit_hi +: 8] <= mem_wdata[15:8];
        end
    end

`ifdef DM_CACHE_PERF_EN
    logic        after_fill;
    logic [15:0] hit_cnt_q;
    logic [15:0] miss_cnt_q;

    // A response in the cycle right after a fill belongs to the miss, not to a hit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            after_fill <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            after_fill <= fill_en;
            if (mem_resp && !after_fill) hit_cnt_q <= hit_cnt_q + 16'd1;
            if (miss_start) miss_cnt_q <= miss_cnt_q + 16'd1;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_dm_cache.sv
// Self-checking bench for dm_cache: directed vector table, multi-cycle corner sequences,
// and randomized traffic checked against a flat-memory reference model with a pmem responder.
module tb_dm_cache;
    localparam int NUM_SETS = 8;
    localparam int IDX_W    = 3;
`ifdef DM_CACHE_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic         clk, reset;
    logic         mem_read, mem_write;
    logic [15:0]  mem_address, mem_wdata;
    logic [1:0]   mem_byte_enable;
    logic         mem_resp;
    logic [15:0]  mem_rdata;
    logic         pmem_read, pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata, pmem_rdata;
    logic         pmem_resp;
    logic [15:0]  hit_count, miss_count;

    dm_cache #(.NUM_SETS(NUM_SETS)) dut (
        .clk(clk), .reset(reset),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    initial forever @(posedge clk) cyc++;

    // Physical memory: written lines live here; untouched lines have a fixed address pattern.
    logic [127:0] pmem_mem [int];
    int           lat_cfg = 2;
    int           resp_wait = 0;
    int           wb_count = 0, rd_count = 0, proto_err = 0, last_presp_cyc = 0;
    logic [15:0]  last_rd_addr = '0, last_wb_addr = '0;

    function automatic logic [127:0] line_of(input int ln);
        logic [127:0] l;
        logic [15:0]  a;
        if (pmem_mem.exists(ln)) return pmem_mem[ln];
        for (int w = 0; w < 8; w++) begin
            a = 16'(ln * 16 + w * 2);
            l[w*16 +: 16] = a ^ 16'hA5A5;
        end
        return l;
    endfunction

    initial begin
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(negedge clk);
            if (pmem_resp) begin
                pmem_resp = 1'b0;
                resp_wait = 0;
            end else if (reset) begin
                resp_wait = 0;
            end else if (pmem_read || pmem_write) begin
                if (pmem_read && pmem_write) proto_err++;
                if (pmem_address[3:0] != 4'h0) proto_err++;
                resp_wait++;
                if (resp_wait >= lat_cfg) begin
                    if (pmem_write) begin
                        pmem_mem[int'(pmem_address[15:4])] = pmem_wdata;
                        last_wb_addr = pmem_address;
                        wb_count++;
                    end else begin
                        pmem_rdata   = line_of(int'(pmem_address[15:4]));
                        last_rd_addr = pmem_address;
                        rd_count++;
                    end
                    pmem_resp      = 1'b1;
                    last_presp_cyc = cyc;
                end
            end else begin
                resp_wait = 0;
            end
        end
    end

    // Reference model: a flat word memory plus which tag each set holds and whether it is dirty.
    logic [15:0] golden [int];
    bit          res_valid [NUM_SETS];
    bit          res_dirty [NUM_SETS];
    int          res_tag   [NUM_SETS];
    int          exp_hits = 0, exp_misses = 0;

    function automatic logic [15:0] golden_word(input logic [15:0] a);
        logic [127:0] l;
        if (golden.exists(int'(a) >> 1)) return golden[int'(a) >> 1];
        l = line_of(int'(a) >> 4);
        return l[int'(a[3:1])*16 +: 16];
    endfunction

    function automatic void golden_write(input logic [15:0] a, input logic [15:0] wd, input logic [1:0] be);
        logic [15:0] cur;
        cur = golden_word(a);
        if (be[0]) cur[7:0]  = wd[7:0];
        if (be[1]) cur[15:8] = wd[15:8];
        golden[int'(a) >> 1] = cur;
    endfunction

    function automatic void model_access(input logic [15:0] a, input bit is_wr, input logic [1:0] be,
                                         output bit hit, output bit wb);
        int idx, tg;
        idx = (int'(a) >> 4) % NUM_SETS;
        tg  = int'(a) >> (4 + IDX_W);
        hit = res_valid[idx] && (res_tag[idx] == tg);
        wb  = !hit && res_valid[idx] && res_dirty[idx];
        if (!hit) begin
            res_valid[idx] = 1'b1;
            res_tag[idx]   = tg;
            res_dirty[idx] = 1'b0;
        end
        if (is_wr && be != 2'b00) res_dirty[idx] = 1'b1;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < NUM_SETS; i++) begin
            res_valid[i] = 1'b0;
            res_dirty[i] = 1'b0;
        end
        golden.delete();
        exp_hits   = 0;
        exp_misses = 0;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        clear_model();
    endtask

    // One CPU transaction, entered and left one time unit after a rising edge.
    task automatic do_op(input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] wd,
                         input logic [1:0] be, output bit got, output logic [15:0] rdata,
                         output int lat, output int wbn, output int resp_cyc);
        int wb0;
        wb0 = wb_count;
        got = 1'b0; rdata = '0; lat = 0; resp_cyc = 0;
        mem_read = rd; mem_write = wr; mem_address = a; mem_wdata = wd; mem_byte_enable = be;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (mem_resp) begin
                got = 1'b1; rdata = mem_rdata; lat = n; resp_cyc = cyc;
                break;
            end
        end
        @(posedge clk);
        #1;
        mem_read = 1'b0; mem_write = 1'b0;
        wbn = wb_count - wb0;
    endtask

    task automatic run_checked(input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] wd,
                               input logic [1:0] be, input string tag);
        bit eh, ew, got;
        logic [15:0] er, rdata;
        int lat, wbn, rc;
        model_access(a, wr, be, eh, ew);
        er = golden_word(a);
        do_op(rd, wr, a, wd, be, got, rdata, lat, wbn, rc);
        check({tag, "_done"}, got, 1'b1);
        check({tag, "_hit"}, lat == 0, eh);
        check({tag, "_wb"}, wbn, ew);
        if (!wr) check({tag, "_rdata"}, rdata, er);
        if (wr) golden_write(a, wd, be);
        if (eh) exp_hits++; else exp_misses++;
    endtask

    typedef struct {
        bit          rd;
        bit          wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [1:0]  be;
        bit          exp_hit;
        int          exp_wb;
        bit          chk_rdata;
        logic [15:0] exp_rdata;
        logic [15:0] exp_fill;
        logic [15:0] exp_wb_addr;
    } vec_t;

    vec_t vecs[$];

    function automatic void add_vec(bit rd, bit wr, logic [15:0] a, logic [15:0] wd, logic [1:0] be,
                                    bit eh, int ewb, bit chk, logic [15:0] er, logic [15:0] ef,
                                    logic [15:0] ewa);
        vec_t v;
        v = '{rd, wr, a, wd, be, eh, ewb, chk, er, ef, ewa};
        vecs.push_back(v);
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit           got, seen;
        logic [15:0]  rdata;
        logic [127:0] pl;
        int           lat, wbn, rc, rd0, resp_seen;

        reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
        mem_address = '0; mem_wdata = '0; mem_byte_enable = '0;
        pl = line_of(32'h123);
        pl[47:32] = 16'hBEEF;
        pmem_mem[32'h123] = pl;
        clear_model();

        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_resp", mem_resp, 1'b0);
        check("rst_mem_rdata", mem_rdata, 16'h0);
        check("rst_pmem_read", pmem_read, 1'b0);
        check("rst_pmem_write", pmem_write, 1'b0);
        check("rst_pmem_address", pmem_address, 16'h0);
        check("rst_pmem_wdata", pmem_wdata, 128'h0);
        check("rst_hit_count", hit_count, 16'h0);
        check("rst_miss_count", miss_count, 16'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        //      rd wr addr     wdata    be     hit wb chk rdata    fill     wb_addr
        add_vec(1, 0, 16'h1234, 16'h0000, 2'b00, 0, 0, 1, 16'hBEEF, 16'h1230, 16'h0000);
        add_vec(1, 0, 16'h1234, 16'h0000, 2'b00, 1, 0, 1, 16'hBEEF, 16'h0000, 16'h0000);
        add_vec(0, 1, 16'h1234, 16'hAA55, 2'b01, 1, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        add_vec(1, 0, 16'h1234, 16'h0000, 2'b00, 1, 0, 1, 16'hBE55, 16'h0000, 16'h0000);
        add_vec(0, 1, 16'h1236, 16'h1234, 2'b00, 1, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        add_vec(1, 0, 16'h1236, 16'h0000, 2'b00, 1, 0, 1, 16'hB793, 16'h0000, 16'h0000);
        add_vec(1, 0, 16'h12B4, 16'h0000, 2'b00, 0, 1, 1, 16'hB711, 16'h12B0, 16'h1230);
        add_vec(0, 1, 16'h12B6, 16'hFFFF, 2'b10, 1, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        add_vec(1, 0, 16'h12B6, 16'h0000, 2'b00, 1, 0, 1, 16'hFF13, 16'h0000, 16'h0000);
        add_vec(1, 0, 16'h1234, 16'h0000, 2'b00, 0, 1, 1, 16'hBE55, 16'h1230, 16'h12B0);
        add_vec(1, 0, 16'h0000, 16'h0000, 2'b00, 0, 0, 1, 16'hA5A5, 16'h0000, 16'h0000);
        add_vec(0, 1, 16'h0004, 16'hFFFF, 2'b00, 1, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        add_vec(1, 0, 16'h0080, 16'h0000, 2'b00, 0, 0, 1, 16'hA525, 16'h0080, 16'h0000);
        add_vec(1, 0, 16'h0004, 16'h0000, 2'b00, 0, 0, 1, 16'hA5A1, 16'h0000, 16'h0000);
        add_vec(0, 1, 16'h000E, 16'h1357, 2'b11, 1, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        add_vec(1, 0, 16'h000E, 16'h0000, 2'b00, 1, 0, 1, 16'h1357, 16'h0000, 16'h0000);
        add_vec(1, 1, 16'h0002, 16'h2468, 2'b11, 1, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        add_vec(1, 0, 16'h0002, 16'h0000, 2'b00, 1, 0, 1, 16'h2468, 16'h0000, 16'h0000);
        add_vec(1, 0, 16'h0003, 16'h0000, 2'b00, 1, 0, 1, 16'h2468, 16'h0000, 16'h0000);

        foreach (vecs[i]) begin
            rd0 = rd_count;
            do_op(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be, got, rdata, lat, wbn, rc);
            check($sformatf("vec%0d_done", i), got, 1'b1);
            check($sformatf("vec%0d_hit", i), lat == 0, vecs[i].exp_hit);
            check($sformatf("vec%0d_wb", i), wbn, vecs[i].exp_wb);
            check($sformatf("vec%0d_fills", i), rd_count - rd0, vecs[i].exp_hit ? 0 : 1);
            if (vecs[i].chk_rdata) check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
            if (!vecs[i].exp_hit) begin
                check($sformatf("vec%0d_miss_latency", i), rc - last_presp_cyc, 1);
                check($sformatf("vec%0d_fill_addr", i), last_rd_addr, vecs[i].exp_fill);
            end
            if (vecs[i].exp_wb != 0) check($sformatf("vec%0d_wb_addr", i), last_wb_addr, vecs[i].exp_wb_addr);
        end
        pl = pmem_mem[32'h123];
        check("wb_line_word2", pl[47:32], 16'hBE55);

        // Reset asserted between clock edges while a fill is outstanding.
        lat_cfg = 8;
        mem_address = 16'h0450; mem_read = 1'b1; seen = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(negedge clk);
            seen = pmem_read;
        end
        check("mf_fill_started", seen, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("mf_pmem_read_async", pmem_read, 1'b0);
        check("mf_mem_resp_async", mem_resp, 1'b0);
        check("mf_pmem_address_async", pmem_address, 16'h0);
        mem_read = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        clear_model();
        lat_cfg = 2;
        do_op(1, 0, 16'h0450, 16'h0, 2'b00, got, rdata, lat, wbn, rc);
        check("mf_reread_done", got, 1'b1);
        check("mf_reread_misses", lat > 0, 1'b1);
        check("mf_reread_rdata", rdata, 16'hA1F5);

        // Request withdrawn mid-fill: the fill still completes, with no response.
        lat_cfg = 3;
        rd0 = rd_count;
        mem_address = 16'h0460; mem_read = 1'b1; seen = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(negedge clk);
            seen = pmem_read;
        end
        check("drop_fill_started", seen, 1'b1);
        mem_read = 1'b0;
        resp_seen = 0;
        for (int n = 0; n < 15; n++) begin
            @(negedge clk);
            if (mem_resp) resp_seen++;
        end
        check("drop_no_resp", resp_seen, 0);
        check("drop_fill_completed", rd_count - rd0, 1);
        @(posedge clk);
        #1;
        do_op(1, 0, 16'h0460, 16'h0, 2'b00, got, rdata, lat, wbn, rc);
        check("drop_later_done", got, 1'b1);
        check("drop_later_hit", lat, 0);
        check("drop_later_rdata", rdata, 16'hA1C5);

        // One miss followed by three hits from a clean reset.
        do_reset();
        lat_cfg = 2;
        run_checked(1, 0, 16'h0800, 16'h0, 2'b00, "perf0");
        run_checked(1, 0, 16'h0800, 16'h0, 2'b00, "perf1");
        run_checked(1, 0, 16'h0802, 16'h0, 2'b00, "perf2");
        run_checked(1, 0, 16'h0804, 16'h0, 2'b00, "perf3");
        check("perf_miss_count", miss_count, PERF_ON ? 16'd1 : 16'd0);
        check("perf_hit_count", hit_count, PERF_ON ? 16'd3 : 16'd0);

        // Random traffic over a few tags per set.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            logic [15:0] a;
            int kind;
            a = 16'((10 + $urandom_range(0, 2)) << 7) | 16'($urandom_range(0, NUM_SETS - 1) << 4)
              | 16'($urandom_range(0, 7) << 1) | 16'($urandom_range(0, 1));
            kind = $urandom_range(0, 3);
            lat_cfg = $urandom_range(1, 4);
            run_checked(kind != 2, kind >= 2, a, 16'($urandom), 2'($urandom_range(0, 3)),
                        $sformatf("rnd%0d", i));
        end
        check("rnd_miss_count", miss_count, PERF_ON ? 16'(exp_misses) : 16'd0);
        check("rnd_hit_count", hit_count, PERF_ON ? 16'(exp_hits) : 16'd0);
        check("pmem_protocol", proto_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
